// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM and its neighbours (ula_control).
// Contents:
//   - opcode constants (instruction register [31:26])
//   - ula_operation codes handed to ula_control
//   - state encoding (IDLE=0 .. JUMP=12), exposed on state_o for debug
//   - opcode class record produced by the opcode class decoder
package multicycle_control_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ula_operation codes expanded by ula_control
  localparam logic [2:0] ULA_OP_ADD  = 3'b000;
  localparam logic [2:0] ULA_OP_SUB  = 3'b001;
  localparam logic [2:0] ULA_OP_FUNC = 3'b010;
  localparam logic [2:0] ULA_OP_SLTI = 3'b011;
  localparam logic [2:0] ULA_OP_ANDI = 3'b100;
  localparam logic [2:0] ULA_OP_ORI  = 3'b101;
  localparam logic [2:0] ULA_OP_XORI = 3'b110;

  // FSM states; codes 13..15 are unused and recover to StIdle
  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StIExec    = 4'd9,
    StIWb      = 4'd10,
    StBranch   = 4'd11,
    StJump     = 4'd12
  } state_e;

  typedef struct packed {
    logic is_mem;     // lw or sw
    logic is_lw;
    logic is_r;
    logic is_branch;  // beq or bne
    logic is_jump;
    logic is_imm;     // addi/slti/andi/ori/xori
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main control FSM and the multicycle datapath.
//   master : the control FSM (drives strobes, samples opcode and mem_ready)
//   slave  : the datapath/memory side
// Signals: opcode[5:0], mem_ready, pc_write, pc_write_cond, branch_ne, pc_source[1:0], i_or_d,
//          mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//          alu_src_b[1:0], ula_operation[2:0], illegal_op, state_o[3:0]
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] ula_operation;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ula_operation,
           illegal_op, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ula_operation,
           illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_control_opcode_class_decoder.sv
// Combinational opcode classifier for the main control FSM.
// Ports:
//   opcode  in  6  instruction register [31:26]
//   cls     out    {is_mem, is_lw, is_r, is_branch, is_jump, is_imm, illegal}
//   imm_op  out 3  ula_operation for the I-type ALU instructions (ADD when not I-type)
module multicycle_control_opcode_class_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  output opclass_t   cls,
  output logic [2:0] imm_op
);

  always_comb begin
    cls    = '0;
    imm_op = ULA_OP_ADD;
    case (opcode)
      OP_LW: begin
        cls.is_mem = 1'b1;
        cls.is_lw  = 1'b1;
      end
      OP_SW:          cls.is_mem    = 1'b1;
      OP_RTYPE:       cls.is_r      = 1'b1;
      OP_BEQ, OP_BNE: cls.is_branch = 1'b1;
      OP_J:           cls.is_jump   = 1'b1;
      OP_ADDI: begin
        cls.is_imm = 1'b1;
        imm_op     = ULA_OP_ADD;
      end
      OP_SLTI: begin
        cls.is_imm = 1'b1;
        imm_op     = ULA_OP_SLTI;
      end
      OP_ANDI: begin
        cls.is_imm = 1'b1;
        imm_op     = ULA_OP_ANDI;
      end
      OP_ORI: begin
        cls.is_imm = 1'b1;
        imm_op     = ULA_OP_ORI;
      end
      OP_XORI: begin
        cls.is_imm = 1'b1;
        imm_op     = ULA_OP_XORI;
      end
      default:        cls.illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (feeds ula_control).
// Sequences fetch/decode/execute/memory/writeback per opcode and stalls on mem_ready.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          multicycle_control_if.master: opcode/mem_ready in, datapath strobes,
//                ula_operation, illegal_op and state_o out
//   cycle_cnt    (CTRL_PERF_COUNTERS_EN only) cycles spent outside IDLE
//   retired_cnt  (CTRL_PERF_COUNTERS_EN only) legal instructions completed
// Optional feature macro: CTRL_PERF_COUNTERS_EN (adds the two counters; absent by default).
// Outputs are decoded combinationally from the state register, so an asynchronous reset drops
// every strobe immediately.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_if.master      bus
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] cycle_cnt,
  output logic [PERF_CNT_WIDTH-1:0] retired_cnt
`endif
);

  if (PERF_CNT_WIDTH == 0) begin : g_bad_width
    $error("PERF_CNT_WIDTH must be at least 1");
  end

  state_e     state_q, state_d;
  opclass_t   cls;
  logic [2:0] imm_op;

  multicycle_control_opcode_class_decoder u_decoder (
    .opcode (bus.opcode),
    .cls    (cls),
    .imm_op (imm_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     state_d = StFetch;
      StFetch:    if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        if      (cls.is_mem)    state_d = StMemAddr;
        else if (cls.is_r)      state_d = StRExec;
        else if (cls.is_branch) state_d = StBranch;
        else if (cls.is_jump)   state_d = StJump;
        else if (cls.is_imm)    state_d = StIExec;
        else                    state_d = StFetch;  // illegal: treated as a NOP
      end
      StMemAddr:  state_d = cls.is_lw ? StMemRead : StMemWrite;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (bus.mem_ready) state_d = StFetch;
      StRExec:    state_d = StRWb;
      StRWb:      state_d = StFetch;
      StIExec:    state_d = StIWb;
      StIWb:      state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_source     = 2'b00;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.ula_operation = ULA_OP_ADD;
    bus.illegal_op    = 1'b0;
    bus.state_o       = state_q;
    case (state_q)
      StFetch: begin
        // PC+4 computed every fetch cycle, but IR/PC only load on the completing cycle
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      StDecode: begin
        // Branch target into ALUOut ahead of a possible BRANCH
        bus.alu_src_b  = 2'b11;
        bus.illegal_op = cls.illegal;
      end
      StMemAddr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      StMemRead: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      StRExec: begin
        bus.alu_src_a     = 1'b1;
        bus.ula_operation = ULA_OP_FUNC;
      end
      StRWb: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      StIExec: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = 2'b10;
        bus.ula_operation = imm_op;
      end
      StIWb:   bus.reg_write = 1'b1;
      StBranch: begin
        bus.alu_src_a     = 1'b1;
        bus.ula_operation = ULA_OP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.branch_ne     = (bus.opcode == OP_BNE);
      end
      StJump: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      default: ;
    endcase
  end

`ifdef CTRL_PERF_COUNTERS_EN
  logic                      retire;
  logic [PERF_CNT_WIDTH-1:0] cycle_q, retired_q;

  // Completion of a legal instruction; DECODE->FETCH only happens for illegal opcodes
  assign retire = (state_d == StFetch) &&
                  !(state_q inside {StIdle, StFetch, StDecode});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if (state_q != StIdle) cycle_q   <= cycle_q + PERF_CNT_WIDTH'(1);
      if (retire)            retired_q <= retired_q + PERF_CNT_WIDTH'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. The reference model walks a per-opcode
// list of phases and derives expected strobes from each phase's description; latency is checked
// against the per-class cycle budget plus observed memory stalls.
module tb_multicycle_control;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_READ = 4,
                 S_MEM_WB = 5, S_MEM_WRITE = 6, S_R_EXEC = 7, S_R_WB = 8, S_I_EXEC = 9,
                 S_I_WB = 10, S_BRANCH = 11, S_JUMP = 12;

  logic clk;
  logic rst_n;

  multicycle_control_if bus ();

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  multicycle_control #(
    .PERF_CNT_WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] got_vec;
  assign got_vec = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_source, bus.i_or_d,
                    bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                    bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.ula_operation,
                    bus.illegal_op};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [5:0] legal_ops [11] = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000,
                                 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b100011,
                                 6'b101011};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int latency(input logic [5:0] op);
    case (op)
      6'b100011:                                            return 5;
      6'b101011, 6'b000000:                                 return 4;
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: return 4;
      6'b000100, 6'b000101, 6'b000010:                      return 3;
      default:                                              return 2;
    endcase
  endfunction

  function automatic logic [2:0] imm_code(input logic [5:0] op);
    case (op)
      6'b001010: return 3'b011;
      6'b001100: return 3'b100;
      6'b001101: return 3'b101;
      6'b001110: return 3'b110;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] op, input bit rdy);
    logic pcw, pcwc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] pcs, asb;
    logic [2:0] ulo;
    {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, ill} = '0;
    pcs = 2'b00; asb = 2'b00; ulo = 3'b000;
    case (st)
      S_FETCH:     begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:    begin asb = 2'b11; ill = !is_legal(op); end
      S_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      S_MEM_READ:  begin mr = 1; iord = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WRITE: begin mw = 1; iord = 1; end
      S_R_EXEC:    begin asa = 1; ulo = 3'b010; end
      S_R_WB:      begin rw = 1; rdst = 1; end
      S_I_EXEC:    begin asa = 1; asb = 2'b10; ulo = imm_code(op); end
      S_I_WB:      rw = 1;
      S_BRANCH:    begin asa = 1; ulo = 3'b001; pcwc = 1; pcs = 2'b01; bne = (op == 6'b000101); end
      S_JUMP:      begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, bne, pcs, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, ulo, ill};
  endfunction

  int         m_route[$];
  int         m_idx, m_state, m_stalls;
  logic [5:0] cur_op, done_op, force_op;
  bit         need_op, force_en;
  int         done_stalls;
  logic [31:0] m_cyc, m_ret;
  int         dut_cnt, prev_st;

  function automatic void build_route(input logic [5:0] op);
    m_route = {S_FETCH, S_DECODE};
    case (op)
      6'b100011: begin m_route.push_back(S_MEM_ADDR); m_route.push_back(S_MEM_READ);
                       m_route.push_back(S_MEM_WB); end
      6'b101011: begin m_route.push_back(S_MEM_ADDR); m_route.push_back(S_MEM_WRITE); end
      6'b000000: begin m_route.push_back(S_R_EXEC); m_route.push_back(S_R_WB); end
      6'b000100, 6'b000101: m_route.push_back(S_BRANCH);
      6'b000010: m_route.push_back(S_JUMP);
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
        m_route.push_back(S_I_EXEC); m_route.push_back(S_I_WB);
      end
      default: ;
    endcase
  endfunction

  function automatic void start_instr();
    m_state = S_FETCH; m_idx = 0; m_stalls = 0; need_op = 1'b1;
  endfunction

  function automatic void advance(input bit rdy);
    if (m_state != S_IDLE) m_cyc++;
    if (m_state == S_IDLE) start_instr();
    else if ((m_state == S_FETCH || m_state == S_MEM_READ || m_state == S_MEM_WRITE) && !rdy)
      m_stalls++;
    else begin
      m_idx++;
      if (m_idx >= m_route.size()) begin
        if (is_legal(cur_op)) m_ret++;
        done_op = cur_op; done_stalls = m_stalls;
        start_instr();
      end else m_state = m_route[m_idx];
    end
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_cyc = '0; m_ret = '0; need_op = 1'b0;
    dut_cnt = 0; prev_st = S_IDLE;
  endfunction

  // Called just after a negedge; returns just after the following negedge.
  task automatic do_cycle(input bit rdy);
    if (need_op) begin
      if (force_en) cur_op = force_op;
      else if ($urandom_range(0, 9) < 8) cur_op = legal_ops[$urandom_range(0, 10)];
      else cur_op = 6'($urandom);
      need_op = 1'b0;
      build_route(cur_op);
    end
    bus.opcode    = cur_op;
    bus.mem_ready = rdy;
    #1;
    check("state", 32'(bus.state_o), 32'(m_state));
    check("ctrl", 32'(got_vec), 32'(exp_ctrl(m_state, cur_op, rdy)));
    if (int'(bus.state_o) == S_FETCH && prev_st != S_FETCH && prev_st != S_IDLE) begin
      check("latency", 32'(dut_cnt), 32'(latency(done_op) + done_stalls));
      dut_cnt = 0;
    end
    if (int'(bus.state_o) != S_IDLE) dut_cnt++;
    prev_st = int'(bus.state_o);
`ifdef CTRL_PERF_COUNTERS_EN
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("retired_cnt", retired_cnt, m_ret);
`endif
    @(posedge clk);
    advance(rdy);
    @(negedge clk);
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b0;
    cur_op = '0; done_op = '0; done_stalls = 0; force_en = 1'b0; force_op = 6'b101011;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(bus.state_o), S_IDLE);
    check("reset_ctrl", 32'(got_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) do_cycle($urandom_range(0, 3) != 0);

    // Drive a sw into MEM_WRITE, hold mem_ready low, and reset asynchronously mid-access
    force_en = 1'b1;
    reached  = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (m_state == S_MEM_WRITE) reached = 1'b1;
      else do_cycle(1'b1);
    end
    check("reach_mem_write", 32'(reached), 32'd1);
    bus.mem_ready = 1'b0;
    #1;
    check("mem_write_held", 32'(bus.mem_write), 32'(reached));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.state_o), S_IDLE);
    check("async_rst_ctrl", 32'(got_vec), 32'd0);
`ifdef CTRL_PERF_COUNTERS_EN
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_retired_cnt", retired_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    force_en = 1'b0;
    model_reset();
    for (int i = 0; i < 300; i++) do_cycle($urandom_range(0, 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
